// File: rtl/clock_pkg.sv
// Shared time-of-day widths/limits and alarm channel state for the alarm bank.
// Also provides the minute-add helper used for snooze targets.
package clock_pkg;

  localparam int         TIME_W  = 6;
  localparam logic [5:0] MAX_HR  = 6'd23;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [5:0] MAX_SEC = 6'd59;

  typedef enum logic [1:0] {
    CH_DISARMED,
    CH_ARMED,
    CH_RINGING,
    CH_SNOOZED
  } ch_state_e;

  typedef struct packed {
    logic [TIME_W-1:0] hr;
    logic [TIME_W-1:0] mn;
  } hm_t;

  // Adds up to 59 minutes to an hh:mm, carrying into hours and wrapping past midnight.
  function automatic hm_t add_minutes(input logic [TIME_W-1:0] hr,
                                      input logic [TIME_W-1:0] mn,
                                      input logic [TIME_W-1:0] delta);
    hm_t        res;
    logic [6:0] m_sum;
    m_sum  = {1'b0, mn} + {1'b0, delta};
    res.hr = hr;
    if (m_sum > {1'b0, MAX_MIN}) begin
      m_sum  = m_sum - 7'd60;
      res.hr = (hr == MAX_HR) ? '0 : hr + 6'd1;
    end
    res.mn = m_sum[TIME_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: programmed time, ring timeout and snooze bookkeeping.
// Write strobe has priority over every time match or button event.
module alarm_channel
  import clock_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [TIME_W-1:0] cur_hr,
  input  logic [TIME_W-1:0] cur_min,
  input  logic [TIME_W-1:0] cur_sec,
  input  logic              wr_sel,
  input  logic [TIME_W-1:0] wr_hr,
  input  logic [TIME_W-1:0] wr_min,
  input  logic              wr_arm,
  input  logic              wr_repeat,
  input  logic              snooze_btn,
  input  logic              stop_btn,
  output logic              ringing,
  output logic              armed
);

  localparam logic [TIME_W-1:0] SNOOZE_DELTA = TIME_W'(SNOOZE_MIN);
  localparam logic [7:0]        RING_LAST    = 8'(RING_SEC - 1);
  localparam logic [7:0]        SNOOZE_LIM   = 8'(MAX_SNOOZE);

  ch_state_e         state_q, state_d;
  logic [TIME_W-1:0] hr_q, hr_d, min_q, min_d;
  logic [TIME_W-1:0] tgt_hr_q, tgt_hr_d, tgt_min_q, tgt_min_d;
  logic              rep_q, rep_d;
  logic [7:0]        ring_cnt_q, ring_cnt_d;
  logic [7:0]        snz_cnt_q, snz_cnt_d;

  logic go_stop;
  hm_t  snz_tgt;

  always_comb begin
    state_d    = state_q;
    hr_d       = hr_q;
    min_d      = min_q;
    rep_d      = rep_q;
    tgt_hr_d   = tgt_hr_q;
    tgt_min_d  = tgt_min_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    go_stop    = 1'b0;
    snz_tgt    = add_minutes(cur_hr, cur_min, SNOOZE_DELTA);

    if (wr_sel) begin
      hr_d       = wr_hr;
      min_d      = wr_min;
      rep_d      = wr_repeat;
      state_d    = wr_arm ? CH_ARMED : CH_DISARMED;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else begin
      case (state_q)
        CH_ARMED: begin
          if (tick && cur_sec == '0 && cur_hr == hr_q && cur_min == min_q) begin
            state_d    = CH_RINGING;
            ring_cnt_d = '0;
          end
        end
        CH_RINGING: begin
          // Stop beats snooze; an exhausted snooze budget degrades to stop.
          if (stop_btn || (snooze_btn && snz_cnt_q >= SNOOZE_LIM)) begin
            go_stop = 1'b1;
          end else if (snooze_btn) begin
            state_d   = CH_SNOOZED;
            snz_cnt_d = snz_cnt_q + 8'd1;
            tgt_hr_d  = snz_tgt.hr;
            tgt_min_d = snz_tgt.mn;
          end else if (tick) begin
            if (ring_cnt_q == RING_LAST) go_stop = 1'b1;
            else                         ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end
        CH_SNOOZED: begin
          if (stop_btn) begin
            go_stop = 1'b1;
          end else if (tick && cur_sec == '0 && cur_hr == tgt_hr_q && cur_min == tgt_min_q) begin
            state_d    = CH_RINGING;
            ring_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end

    if (go_stop) begin
      state_d   = rep_q ? CH_ARMED : CH_DISARMED;
      snz_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CH_DISARMED;
      hr_q       <= '0;
      min_q      <= '0;
      rep_q      <= 1'b0;
      tgt_hr_q   <= '0;
      tgt_min_q  <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      rep_q      <= rep_d;
      tgt_hr_q   <= tgt_hr_d;
      tgt_min_q  <= tgt_min_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  assign ringing = (state_q == CH_RINGING);
  assign armed   = (state_q != CH_DISARMED);

endmodule

// File: rtl/alarm_bank.sv
// Bank of independent alarm channels with validated write decode,
// buzzer OR-reduction and lowest-index ringing priority encoder.
module alarm_bank
  import clock_pkg::*;
#(
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3,
  localparam int IDX_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [TIME_W-1:0]   cur_hr,
  input  logic [TIME_W-1:0]   cur_min,
  input  logic [TIME_W-1:0]   cur_sec,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [TIME_W-1:0]   wr_hr,
  input  logic [TIME_W-1:0]   wr_min,
  input  logic                wr_arm,
  input  logic                wr_repeat,
  input  logic                snooze_btn,
  input  logic                stop_btn,
  output logic [N_ALARMS-1:0] ringing,
  output logic                buzzer,
  output logic [N_ALARMS-1:0] armed,
  output logic [IDX_W-1:0]    active_idx
);

  logic                wr_ok;
  logic [N_ALARMS-1:0] ring_raw, armed_raw;

  assign wr_ok = wr_en && (wr_hr <= MAX_HR) && (wr_min <= MAX_MIN)
                 && (int'(wr_idx) < N_ALARMS);

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .SNOOZE_MIN (SNOOZE_MIN),
      .RING_SEC   (RING_SEC),
      .MAX_SNOOZE (MAX_SNOOZE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .cur_hr     (cur_hr),
      .cur_min    (cur_min),
      .cur_sec    (cur_sec),
      .wr_sel     (wr_ok && (wr_idx == IDX_W'(i))),
      .wr_hr      (wr_hr),
      .wr_min     (wr_min),
      .wr_arm     (wr_arm),
      .wr_repeat  (wr_repeat),
      .snooze_btn (snooze_btn),
      .stop_btn   (stop_btn),
      .ringing    (ring_raw[i]),
      .armed      (armed_raw[i])
    );
  end

  // Outputs are masked by reset so a ring goes silent in the reset cycle itself.
  assign ringing = ring_raw  & {N_ALARMS{~reset}};
  assign armed   = armed_raw & {N_ALARMS{~reset}};
  assign buzzer  = |ringing;

  always_comb begin
    active_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (ringing[i]) active_idx = IDX_W'(i);
    end
  end

endmodule
